// File: rtl/data_modulate_nxn_controller_if.sv
// Handshake bundle between the window controller and its upstream/downstream neighbours.
// The master drives the frame/pixel controls; the slave (controller) drives the window strobes.
interface data_modulate_nxn_controller_if #(
  parameter int CW = 10,
  parameter int RW = 10
);
  logic          start_i;
  logic          valid_i;
  logic          done_i;
  logic          stall_i;
  logic          win_valid_o;
  logic [RW-1:0] cen_row_o;
  logic [CW-1:0] cen_col_o;
  logic          flush_o;
  logic          start_o;
  logic          done_o;
  logic          busy_o;

  modport master (
    output start_i, valid_i, done_i, stall_i,
    input  win_valid_o, cen_row_o, cen_col_o, flush_o, start_o, done_o, busy_o
  );

  modport slave (
    input  start_i, valid_i, done_i, stall_i,
    output win_valid_o, cen_row_o, cen_col_o, flush_o, start_o, done_o, busy_o
  );
endinterface

// File: rtl/data_modulate_nxn_controller.sv
// NxN sliding-window sequencer: one registered window strobe per pixel centre, lagging input by
// HALF rows + HALF cols; stall_i freezes only the post-frame flush, which ends in a single done pulse.
module data_modulate_nxn_controller #(
  parameter int KSIZE = 7,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int CW    = 10,
  parameter int RW    = 10,
  parameter int FW    = 16
) (
  input logic                         clk,
  input logic                         rst,
  data_modulate_nxn_controller_if.slave bus
);

  localparam int              HALF       = (KSIZE - 1) / 2;
  localparam int              LAG        = HALF * IMG_W + HALF;
  localparam logic [CW-1:0]   COL_LAST   = CW'(IMG_W - 1);
  localparam logic [RW-1:0]   ROW_LAST   = RW'(IMG_H - 1);
  localparam logic [CW-1:0]   COL_HALF   = CW'(HALF);
  localparam logic [RW-1:0]   ROW_HALF   = RW'(HALF);
  localparam logic [FW-1:0]   FLUSH_LAST = FW'(LAG - 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] in_col, cen_col;
  logic [RW-1:0] in_row, cen_row;
  logic [FW-1:0] flush_cnt;
  logic          done_latch;
  logic          accept, issue, clear, last_px, past_lag;

  assign last_px  = (in_row == ROW_LAST) && (in_col == COL_LAST);
  // Raster index row*IMG_W+col >= HALF*IMG_W+HALF, without a multiplier.
  assign past_lag = (in_row > ROW_HALF) || ((in_row == ROW_HALF) && (in_col >= COL_HALF));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    issue     = 1'b0;
    clear     = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (bus.start_i) begin
          state_nxt = RUN;
          clear     = 1'b1;
        end
      end
      RUN: begin
        accept = bus.valid_i;
        issue  = bus.valid_i && past_lag;
        if (bus.done_i || (bus.valid_i && last_px)) state_nxt = FLUSH;
      end
      FLUSH: begin
        issue = !bus.stall_i;
        if (issue && (flush_cnt == FLUSH_LAST)) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_col          <= '0;
      in_row          <= '0;
      cen_col         <= '0;
      cen_row         <= '0;
      flush_cnt       <= '0;
      done_latch      <= 1'b0;
      bus.win_valid_o <= 1'b0;
      bus.cen_row_o   <= '0;
      bus.cen_col_o   <= '0;
      bus.flush_o     <= 1'b0;
      bus.start_o     <= 1'b0;
      bus.done_o      <= 1'b0;
      bus.busy_o      <= 1'b0;
    end else begin
      bus.win_valid_o <= issue;
      bus.start_o     <= (state == RUN) && (state_nxt == FLUSH);
      bus.flush_o     <= (state_nxt == FLUSH);
      bus.busy_o      <= (state_nxt == RUN) || (state_nxt == FLUSH);
      // First DONE cycle fires the pulse; the latch keeps it from repeating.
      bus.done_o      <= (state == DONE) && !done_latch;
      if (state == DONE) done_latch <= 1'b1;

      if (accept) begin
        if (in_col == COL_LAST) begin
          in_col <= '0;
          in_row <= (in_row == ROW_LAST) ? '0 : in_row + 1'b1;
        end else begin
          in_col <= in_col + 1'b1;
        end
      end

      if (issue) begin
        bus.cen_row_o <= cen_row;
        bus.cen_col_o <= cen_col;
        if (cen_col == COL_LAST) begin
          cen_col <= '0;
          cen_row <= (cen_row == ROW_LAST) ? '0 : cen_row + 1'b1;
        end else begin
          cen_col <= cen_col + 1'b1;
        end
      end

      if ((state == FLUSH) && issue) flush_cnt <= flush_cnt + 1'b1;

      if (clear) begin
        in_col     <= '0;
        in_row     <= '0;
        cen_col    <= '0;
        cen_row    <= '0;
        flush_cnt  <= '0;
        done_latch <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_data_modulate_nxn_controller.sv
// Bench for the window sequencer: two configurations, directed frames plus randomized gaps/stalls,
// scored against a raster-order model of the expected centre sequence and pulse timing.
module tb_data_modulate_nxn_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic start, valid, done, stall;
  bit   sel;

  data_modulate_nxn_controller_if bus_a ();
  data_modulate_nxn_controller_if bus_b ();

  assign bus_a.start_i = !sel && start;
  assign bus_a.valid_i = !sel && valid;
  assign bus_a.done_i  = !sel && done;
  assign bus_a.stall_i = !sel && stall;
  assign bus_b.start_i = sel && start;
  assign bus_b.valid_i = sel && valid;
  assign bus_b.done_i  = sel && done;
  assign bus_b.stall_i = sel && stall;

  data_modulate_nxn_controller #(.KSIZE(3), .IMG_W(4), .IMG_H(3), .CW(10), .RW(10), .FW(16))
    dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
  data_modulate_nxn_controller #(.KSIZE(7), .IMG_W(16), .IMG_H(8), .CW(10), .RW(10), .FW(16))
    dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

  logic       wv, fo, so, dn, by;
  logic [9:0] crow, ccol;
  assign wv   = sel ? bus_b.win_valid_o : bus_a.win_valid_o;
  assign fo   = sel ? bus_b.flush_o     : bus_a.flush_o;
  assign so   = sel ? bus_b.start_o     : bus_a.start_o;
  assign dn   = sel ? bus_b.done_o      : bus_a.done_o;
  assign by   = sel ? bus_b.busy_o      : bus_a.busy_o;
  assign crow = sel ? bus_b.cen_row_o   : bus_a.cen_row_o;
  assign ccol = sel ? bus_b.cen_col_o   : bus_a.cen_col_o;

  int nvec, nerr, cyc;
  int W, H, LAG;
  int strobes, run_strobes, flush_cycles, start_cnt, done_cnt;
  int first_cyc, start_cyc, done_cyc, last_cyc, exp_idx;

  task automatic chk(input string tag, input int obs, input int exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Model: the k-th strobe of a frame carries centre (k / W, k % W).
  task automatic observe();
    if (wv) begin
      chk("cen_row", int'(crow), exp_idx / W);
      chk("cen_col", int'(ccol), exp_idx % W);
      if (strobes == 0) first_cyc = cyc;
      strobes++;
      exp_idx++;
      last_cyc = cyc;
    end
    if (fo) flush_cycles++;
    if (so) begin
      start_cnt++;
      start_cyc   = cyc;
      run_strobes = strobes;
    end
    if (dn) begin
      done_cnt++;
      done_cyc = cyc;
    end
  endtask

  task automatic tick(input bit st, input bit v, input bit d, input bit s);
    start = st; valid = v; done = d; stall = s;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    observe();
  endtask

  task automatic clear_stats();
    strobes = 0; run_strobes = -1; flush_cycles = 0; start_cnt = 0; done_cnt = 0;
    first_cyc = -1; start_cyc = -1; done_cyc = -1; last_cyc = -1; exp_idx = 0;
  endtask

  // gapmode <0: random 0..2 idle cycles per pixel; stallmode 0 none, 1 toggle from 1, 2 random.
  task automatic frame(input int npix, input int gapmode, input int stallmode,
                       input bit done_same, input bit start_mid);
    int exp_first, exp_start, budget;
    bit tog, s;
    clear_stats();
    exp_first = -1;
    exp_start = -1;
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    chk("busy_run", int'(by), 1);
    for (int p = 0; p < npix; p++) begin
      int g;
      g = (gapmode < 0) ? int'($urandom_range(0, 2)) : gapmode;
      for (int k = 0; k < g; k++) tick(1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
      tick(start_mid && (p == 3), 1'b1, done_same && (p == npix - 1), 1'($urandom_range(0, 1)));
      if (p == LAG) exp_first = cyc;
      if ((p == npix - 1) && ((npix == W * H) || done_same)) exp_start = cyc;
    end
    if ((npix != W * H) && !done_same) begin
      tick(1'b0, 1'b0, 1'b1, 1'b0);
      exp_start = cyc;
    end
    tog = 1'b1;
    budget = 0;
    while ((done_cnt == 0) && (budget < 4 * LAG + 20)) begin
      s = (stallmode == 0) ? 1'b0 : (stallmode == 1) ? tog : 1'($urandom_range(0, 1));
      tog = !tog;
      if (stallmode == 2) tick(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), s);
      else                tick(1'b0, 1'b0, 1'b0, s);
      budget++;
    end
    repeat (4) tick(1'b0, 1'b0, 1'b0, 1'b0);
    chk("strobes", strobes, npix);
    chk("run_strobes", run_strobes, npix - LAG);
    chk("first_latency", first_cyc, exp_first);
    chk("start_cnt", start_cnt, 1);
    chk("start_cycle", start_cyc, exp_start);
    chk("done_cnt", done_cnt, 1);
    chk("done_after_last", done_cyc, last_cyc + 1);
    if (stallmode == 0) chk("flush_cycles", flush_cycles, LAG);
    if (stallmode == 1) chk("flush_cycles", flush_cycles, 2 * LAG);
    chk("busy_idle", int'(by), 0);
    chk("flush_idle", int'(fo), 0);
  endtask

  initial begin
    nvec = 0; nerr = 0; cyc = 0;
    rst = 1'b0; start = 1'b0; valid = 1'b0; done = 1'b0; stall = 1'b0;
    sel = 1'b0; W = 4; H = 3; LAG = 5;
    clear_stats();
    repeat (2) @(negedge clk);
    chk("rst_win_valid", int'(wv), 0);
    chk("rst_cen_row", int'(crow), 0);
    chk("rst_cen_col", int'(ccol), 0);
    chk("rst_flush", int'(fo), 0);
    chk("rst_start", int'(so), 0);
    chk("rst_done", int'(dn), 0);
    chk("rst_busy", int'(by), 0);
    rst = 1'b1;
    tick(1'b0, 1'b1, 1'b1, 1'b0);
    chk("idle_ignores_inputs", int'(by), 0);

    frame(12, 0, 0, 1'b0, 1'b0);
    frame(12, 0, 1, 1'b0, 1'b0);
    frame(8, 0, 0, 1'b0, 1'b0);
    frame(12, 0, 0, 1'b1, 1'b0);

    // Reset two flush counts into the frame: everything clears, no done.
    clear_stats();
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (12) tick(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (2) tick(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    chk("abort_win_valid", int'(wv), 0);
    chk("abort_cen", int'(crow) + int'(ccol), 0);
    chk("abort_flush", int'(fo), 0);
    chk("abort_busy", int'(by), 0);
    chk("abort_done", int'(dn), 0);
    done_cnt = 0;
    repeat (3) tick(1'b0, 1'b0, 1'b0, 1'b0);
    chk("abort_no_done", done_cnt, 0);
    rst = 1'b1;
    frame(12, 0, 0, 1'b0, 1'b0);

    frame(12, -1, 2, 1'b0, 1'b0);
    frame(int'($urandom_range(6, 11)), -1, 2, 1'b0, 1'b0);

    sel = 1'b1; W = 16; H = 8; LAG = 51;
    frame(128, 2, 0, 1'b0, 1'b1);
    frame(128, -1, 2, 1'b0, 1'b1);
    frame(int'($urandom_range(60, 120)), -1, 1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/data_modulate_nxn_controller.md
Name: data_modulate_nxn_controller

Overview:
Parametrised window-sequencing controller for the NxN data-modulate (sliding-window) stage. It replaces the fixed-size controllers with one block. It tracks the input raster position and issues one window-valid strobe per pixel centre, lagging the input by HALF rows plus HALF columns. After frame end it runs a stallable flush of exactly that lag, then emits a single done pulse. It sits between the line-buffer/shift-register array and the per-window arithmetic (median, Gaussian, Sobel, ...).

Parameters:
KSIZE, 7, kernel size; odd, 3..15; HALF = (KSIZE-1)/2
IMG_W, 640, pixels per row, >= KSIZE
IMG_H, 480, rows per frame, >= KSIZE
CW, 10, width of column counters, 2^CW >= IMG_W
RW, 10, width of row counters, 2^RW >= IMG_H
FW, 16, width of flush counter, 2^FW > HALF*IMG_W+HALF

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  asynchronous, active-low reset
start_i  in  1  frame start pulse; honoured only in IDLE or DONE
valid_i  in  1  input pixel accepted this cycle; honoured only in RUN
done_i  in  1  upstream frame-end strobe; honoured only in RUN
stall_i  in  1  downstream back-pressure; freezes the flush counter in FLUSH
win_valid_o  out  1  window for (cen_row_o, cen_col_o) is valid this cycle
cen_row_o  out  RW  row index of the window centre
cen_col_o  out  CW  column index of the window centre
flush_o  out  1  high while in FLUSH; downstream zero-pads missing rows
start_o  out  1  one-cycle pulse on the RUN->FLUSH transition
done_o  out  1  one-cycle pulse, exactly once per frame
busy_o  out  1  high in RUN or FLUSH

Behaviour:
- Reset (rst=0, async): state=IDLE; all counters 0; all outputs 0; done latch cleared. Reset asserted mid-frame aborts the frame and produces no done_o.
- States: IDLE, RUN, FLUSH, DONE. State is held in registers; all outputs are registered.
- IDLE/DONE: start_i -> RUN. On entry, the input column/row counters, centre counters, flush counter and done latch are all cleared. All other inputs are ignored.
- RUN, per cycle with valid_i=1:
  - Input column increments, wrapping at IMG_W-1 to 0. On wrap, the input row increments.
  - Linear index L = row*IMG_W + col of the accepted pixel.
  - If L >= HALF*IMG_W + HALF: next cycle win_valid_o=1 with the current centre, then the centre advances in raster order (column wraps at IMG_W-1, row increments). Latency is 1 cycle from the accepting edge.
- RUN -> FLUSH when either condition holds, same edge:
  - done_i=1; or
  - valid_i=1 at row IMG_H-1, col IMG_W-1.
  - If both hold in one cycle, one transition occurs. The last pixel's window strobe is still issued.
  - start_o=1 for the following cycle only. If done_i arrives early, remaining input positions are not counted.
- FLUSH:
  - Flush counter counts 0..HALF*IMG_W+HALF-1, advancing only on cycles with stall_i=0.
  - Each advancing cycle issues win_valid_o=1 (registered, 1 cycle later) and advances the centre.
  - stall_i=1: counter, centre and win_valid_o all hold at 0/no strobe; no strobe is lost or duplicated.
  - After the final count, -> DONE. done_o=1 for one cycle, and the done latch sets. done_o never reasserts until the next start_i.
- Totals: a full frame yields exactly IMG_W*IMG_H window strobes, centres (0,0) .. (IMG_H-1, IMG_W-1) in order.
- Centre counters never exceed IMG_H-1 / IMG_W-1. Early done_i truncates the centre sequence to (input count) strobes.
- start_i during RUN or FLUSH is ignored; no restart.
- valid_i and done_i outside RUN are ignored.

Test Plan:
1. KSIZE=3, IMG_W=4, IMG_H=3; reset, start_i, 12 back-to-back valid_i -> first win_valid_o 1 cycle after 6th pixel with centre (0,0); 7 strobes in RUN; start_o after 12th pixel; 5 flush strobes ending at (2,3); done_o one cycle later, once.
2. Same config, stall_i toggling 1/0 every cycle in FLUSH -> still exactly 5 flush strobes, centres contiguous, flush takes 10 cycles, single done_o.
3. Same config, done_i after 8th pixel -> start_o next cycle, 3 RUN strobes + 5 flush = 8 strobes, last centre (1,3), done_o once.
4. done_i and last valid_i in the same cycle -> one transition, one start_o, 12 strobes total, one done_o.
5. rst pulled low during FLUSH at count 2 -> all outputs 0 immediately, no done_o; new start_i gives a clean full frame.
6. KSIZE=7, IMG_W=16, IMG_H=8, gapped valid_i (1 in 3) -> first strobe after pixel 51 (3*16+3); 128 strobes total; done_o once; start_i during RUN has no effect.
